// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: the RAM word and the RAM model's handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response bundle for all cores plus the single RAM port.
interface mem_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
);

    logic [CPUS-1:0] iREN;
    logic [CPUS-1:0] dREN;
    logic [CPUS-1:0] dWEN;
    logic [CPUS-1:0] iwait;
    logic [CPUS-1:0] dwait;
    word_t           iaddr  [CPUS];
    word_t           daddr  [CPUS];
    word_t           dstore [CPUS];
    word_t           iload  [CPUS];
    word_t           dload  [CPUS];

    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;

    // Arbiter side: consumes cache requests and RAM responses.
    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches and RAM model side.
    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_picker #(
    parameter int  N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [PW:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // One spare bit so start+k can exceed N before the wrap.
            idx = {1'b0, start} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!valid && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among the I/D caches of CPUS cores; data beats instruction,
// round-robin across cores, grant held for bursts up to MAX_HOLD accesses.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {ARB, HOLD} arb_state_t;
    typedef enum logic {GT_I, GT_D} gtype_t;

    arb_state_t      state_reg, state_next;
    gtype_t          gtype_reg, gtype_next;
    logic [IW-1:0]   gcpu_reg, gcpu_next;
    logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;

    logic [CPUS-1:0] dreq, ireq;
    logic [CPUS-1:0] dgrant, igrant;
    logic            dvalid, ivalid;
    logic [IW-1:0]   dsel, isel;
    logic            granted_req;
    logic            complete;
    logic            release_now;

    assign dreq = bus.dREN | bus.dWEN;
    assign ireq = bus.iREN;

    rr_picker #(.N(CPUS)) u_dpick (
        .req   (dreq),
        .start (rr_ptr_reg),
        .grant (dgrant),
        .valid (dvalid)
    );

    rr_picker #(.N(CPUS)) u_ipick (
        .req   (ireq),
        .start (rr_ptr_reg),
        .grant (igrant),
        .valid (ivalid)
    );

    always_comb begin
        dsel = '0;
        isel = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (dgrant[k]) dsel = IW'(k);
            if (igrant[k]) isel = IW'(k);
        end
    end

    // A completion only counts while the holder is still asking; a dropped
    // request means the RAM port is idle and any ACCESS is not ours.
    assign granted_req = (state_reg == HOLD) &&
                         ((gtype_reg == GT_D) ? dreq[gcpu_reg] : ireq[gcpu_reg]);
    assign complete    = granted_req && (bus.ramstate == ACCESS);
    assign release_now = (state_reg == HOLD) &&
                         (!granted_req || (complete && hold_cnt_reg == HW'(MAX_HOLD - 1)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= ARB;
            gtype_reg    <= GT_I;
            gcpu_reg     <= '0;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gtype_reg    <= gtype_next;
            gcpu_reg     <= gcpu_next;
            rr_ptr_reg   <= rr_ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gtype_next    = gtype_reg;
        gcpu_next     = gcpu_reg;
        rr_ptr_next   = rr_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = '0;
        bus.ramstore  = '0;

        case (state_reg)
            ARB: begin
                if (dvalid) begin
                    state_next    = HOLD;
                    gtype_next    = GT_D;
                    gcpu_next     = dsel;
                    hold_cnt_next = '0;
                end else if (ivalid) begin
                    state_next    = HOLD;
                    gtype_next    = GT_I;
                    gcpu_next     = isel;
                    hold_cnt_next = '0;
                end
            end

            HOLD: begin
                if (gtype_reg == GT_D) begin
                    // Write wins when a cache raises both strobes.
                    bus.ramWEN   = bus.dWEN[gcpu_reg];
                    bus.ramREN   = bus.dREN[gcpu_reg] & ~bus.dWEN[gcpu_reg];
                    bus.ramaddr  = bus.daddr[gcpu_reg];
                    bus.ramstore = bus.dstore[gcpu_reg];
                end else begin
                    bus.ramREN   = bus.iREN[gcpu_reg];
                    bus.ramaddr  = bus.iaddr[gcpu_reg];
                end

                if (complete && hold_cnt_reg != HW'(MAX_HOLD)) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end

                if (release_now) begin
                    state_next  = ARB;
                    rr_ptr_next = (gcpu_reg == IW'(CPUS - 1)) ? '0 : gcpu_reg + 1'b1;
                end
            end

            default: state_next = ARB;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < CPUS; gi++) begin : g_port
            assign bus.iwait[gi] = !(complete && gtype_reg == GT_I && gcpu_reg == IW'(gi));
            assign bus.dwait[gi] = !(complete && gtype_reg == GT_D && gcpu_reg == IW'(gi));
            assign bus.iload[gi] = bus.ramload;
            assign bus.dload[gi] = bus.ramload;
        end
    endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized cache/RAM traffic against a behavioural arbiter model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS     = 2;
    localparam int MAX_HOLD = 8;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.CPUS(CPUS)) bus ();

    mem_arbiter #(.CPUS(CPUS), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the RAM port (if anyone), how many words it has moved,
    // and where the next round-robin scan starts.
    int m_busy, m_dtype, m_cpu, m_cnt, m_rr;
    int m_done, m_req;
    bit done_d [CPUS];
    bit done_i [CPUS];

    bit d_on [CPUS];
    bit i_on [CPUS];
    int d_kind [CPUS];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_dtype = 0; m_cpu = 0; m_cnt = 0; m_rr = 0;
        for (int c = 0; c < CPUS; c++) begin
            done_d[c] = 0; done_i[c] = 0;
        end
    endtask

    task automatic clear_inputs();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        for (int c = 0; c < CPUS; c++) begin
            bus.iaddr[c] = '0; bus.daddr[c] = '0; bus.dstore[c] = '0;
            d_on[c] = 0; i_on[c] = 0; d_kind[c] = 0;
        end
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    function automatic int has_req(input int is_d, input int c);
        if (is_d != 0) return int'(bus.dREN[c] | bus.dWEN[c]);
        return int'(bus.iREN[c]);
    endfunction

    // Check one cycle's outputs against the model, then advance the model on the clock edge.
    task automatic cycle();
        logic            eren, ewen;
        logic [CPUS-1:0] eiw, edw;
        word_t           eaddr, estore;
        int              found;
        #1;
        eren = 0; ewen = 0; eaddr = '0; estore = '0; eiw = '1; edw = '1;
        m_done = 0; m_req = 0;
        for (int c = 0; c < CPUS; c++) begin
            done_d[c] = 0; done_i[c] = 0;
        end
        if (m_busy != 0) begin
            m_req = has_req(m_dtype, m_cpu);
            if (m_dtype != 0) begin
                ewen   = bus.dWEN[m_cpu];
                eren   = bus.dREN[m_cpu] && !bus.dWEN[m_cpu];
                eaddr  = bus.daddr[m_cpu];
                estore = bus.dstore[m_cpu];
            end else begin
                eren  = bus.iREN[m_cpu];
                eaddr = bus.iaddr[m_cpu];
            end
            m_done = (m_req != 0 && bus.ramstate == ACCESS) ? 1 : 0;
            if (m_done != 0) begin
                if (m_dtype != 0) begin
                    edw[m_cpu] = 1'b0; done_d[m_cpu] = 1;
                end else begin
                    eiw[m_cpu] = 1'b0; done_i[m_cpu] = 1;
                end
                $display("xfer t=%0t core%0d %s addr=%h load=%h", $time, m_cpu,
                         (m_dtype != 0) ? (ewen ? "dwrite" : "dread") : "ifetch", eaddr, bus.ramload);
            end
        end
        check_eq("ramREN", bus.ramREN, eren);
        check_eq("ramWEN", bus.ramWEN, ewen);
        if (eren || ewen) check_eq("ramaddr", bus.ramaddr, eaddr);
        if (ewen) check_eq("ramstore", bus.ramstore, estore);
        check_eq("iwait", bus.iwait, eiw);
        check_eq("dwait", bus.dwait, edw);
        for (int c = 0; c < CPUS; c++) begin
            check_eq("iload", bus.iload[c], bus.ramload);
            check_eq("dload", bus.dload[c], bus.ramload);
        end

        @(posedge CLK);
        if (m_busy == 0) begin
            found = 0;
            for (int k = 0; k < CPUS; k++) begin
                if (found == 0 && has_req(1, (m_rr + k) % CPUS) != 0) begin
                    found = 1; m_dtype = 1; m_cpu = (m_rr + k) % CPUS;
                end
            end
            for (int k = 0; k < CPUS; k++) begin
                if (found == 0 && has_req(0, (m_rr + k) % CPUS) != 0) begin
                    found = 1; m_dtype = 0; m_cpu = (m_rr + k) % CPUS;
                end
            end
            if (found != 0) begin
                m_busy = 1; m_cnt = 0;
            end
        end else begin
            if (m_req == 0 || (m_done != 0 && m_cnt == MAX_HOLD - 1)) begin
                m_busy = 0;
                m_rr   = (m_cpu + 1) % CPUS;
            end
            if (m_done != 0 && m_cnt < MAX_HOLD) m_cnt++;
        end
        @(negedge CLK);
    endtask

    task automatic drive_random();
        int r;
        for (int c = 0; c < CPUS; c++) begin
            if (d_on[c]) begin
                if (done_d[c]) begin
                    if ($urandom_range(0, 99) < 50) d_on[c] = 0;
                    else bus.daddr[c] = bus.daddr[c] + 32'd4;
                end else if ($urandom_range(0, 99) < 3) begin
                    d_on[c] = 0;
                end
            end else if ($urandom_range(0, 99) < 20) begin
                d_on[c]      = 1;
                d_kind[c]    = int'($urandom_range(0, 5));
                bus.daddr[c] = $urandom & 32'h0000_FFFC;
            end
            bus.dREN[c]   = d_on[c] && (d_kind[c] <= 2 || d_kind[c] == 5);
            bus.dWEN[c]   = d_on[c] && (d_kind[c] >= 3);
            bus.dstore[c] = $urandom;

            if (i_on[c]) begin
                if (done_i[c]) begin
                    if ($urandom_range(0, 99) < 50) i_on[c] = 0;
                    else bus.iaddr[c] = bus.iaddr[c] + 32'd4;
                end else if ($urandom_range(0, 99) < 3) begin
                    i_on[c] = 0;
                end
            end else if ($urandom_range(0, 99) < 25) begin
                i_on[c]      = 1;
                bus.iaddr[c] = $urandom & 32'h0000_FFFC;
            end
            bus.iREN[c] = i_on[c];
        end
        r = int'($urandom_range(0, 19));
        if (r < 10)      bus.ramstate = ACCESS;
        else if (r < 15) bus.ramstate = BUSY;
        else if (r < 17) bus.ramstate = ERROR;
        else             bus.ramstate = FREE;
        bus.ramload = $urandom;
    endtask

    initial begin
        nRST = 1'b0;
        clear_inputs();
        m_reset();
        repeat (2) @(negedge CLK);
        #1;
        check_eq("rst_ramREN", bus.ramREN, 1'b0);
        check_eq("rst_ramWEN", bus.ramWEN, 1'b0);
        check_eq("rst_ramaddr", bus.ramaddr, 32'h0);
        check_eq("rst_ramstore", bus.ramstore, 32'h0);
        check_eq("rst_iwait", bus.iwait, 2'b11);
        check_eq("rst_dwait", bus.dwait, 2'b11);
        @(negedge CLK);
        nRST = 1'b1;

        // Single instruction fetch with two BUSY cycles.
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40; bus.ramstate = FREE;
        cycle();
        bus.ramstate = BUSY; #1;
        check_eq("t1_ramREN", bus.ramREN, 1'b1);
        check_eq("t1_ramaddr", bus.ramaddr, 32'h40);
        check_eq("t1_iwait_busy", bus.iwait[0], 1'b1);
        cycle();
        cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_0001; #1;
        check_eq("t1_iwait_done", bus.iwait[0], 1'b0);
        check_eq("t1_iload", bus.iload[0], 32'hCAFE_0001);
        cycle();
        bus.iREN[0] = 1'b0; bus.ramstate = FREE;
        cycle();

        // Data priority over a same-cycle instruction request.
        bus.iREN[0] = 1'b1; bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h200;
        cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'h1234_5678; #1;
        check_eq("t2_ramaddr", bus.ramaddr, 32'h200);
        check_eq("t2_dwait1", bus.dwait[1], 1'b0);
        check_eq("t2_iwait0", bus.iwait[0], 1'b1);
        cycle();
        bus.dREN[1] = 1'b0; bus.ramstate = FREE; #1;
        check_eq("t2_iwait0_drop", bus.iwait[0], 1'b1);
        check_eq("t2_strobe_drop", bus.ramREN, 1'b0);
        cycle();

        // Writeback burst from core 0 while core 1 waits; rr_ptr is back at 0.
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hAAAA_0000;
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h300;
        cycle();
        bus.ramstate = ACCESS; #1;
        check_eq("t3_wen0", bus.ramWEN, 1'b1);
        check_eq("t3_addr0", bus.ramaddr, 32'h100);
        cycle();
        bus.daddr[0] = 32'h104; bus.dstore[0] = 32'hAAAA_0004; #1;
        check_eq("t3_addr1", bus.ramaddr, 32'h104);
        check_eq("t3_store1", bus.ramstore, 32'hAAAA_0004);
        cycle();
        bus.dWEN[0] = 1'b0; bus.iREN[0] = 1'b0; bus.ramstate = FREE; #1;
        check_eq("t3_wen_drop", bus.ramWEN, 1'b0);
        check_eq("t3_dwait1", bus.dwait[1], 1'b1);
        cycle();
        cycle();
        bus.ramstate = ACCESS; #1;
        check_eq("t3_core1_ren", bus.ramREN, 1'b1);
        check_eq("t3_core1_addr", bus.ramaddr, 32'h300);
        cycle();
        bus.dREN[1] = 1'b0; bus.ramstate = FREE;
        cycle();

        // MAX_HOLD cap with a competing data requester.
        bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h500;
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h700;
        bus.ramstate = ACCESS;
        cycle();
        for (int i = 0; i < MAX_HOLD; i++) begin
            bus.daddr[0] = 32'h500 + 32'(4 * i); #1;
            check_eq("t4_burst", bus.dwait[0], 1'b0);
            cycle();
        end
        #1;
        check_eq("t4_cap", bus.dwait[0], 1'b1);
        check_eq("t4_cap_ren", bus.ramREN, 1'b0);
        cycle();
        #1;
        check_eq("t4_next_addr", bus.ramaddr, 32'h700);
        check_eq("t4_next_dwait", bus.dwait[1], 1'b0);
        cycle();
        bus.dREN = '0; bus.ramstate = FREE;
        cycle();

        // Write wins over read; ERROR is retried, not completed.
        bus.dREN[0] = 1'b1; bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h600; bus.dstore[0] = 32'h0BAD_F00D;
        cycle();
        bus.ramstate = ERROR; #1;
        check_eq("t5_wen", bus.ramWEN, 1'b1);
        check_eq("t5_ren", bus.ramREN, 1'b0);
        check_eq("t5_err_dwait", bus.dwait[0], 1'b1);
        cycle();
        bus.ramstate = ACCESS; #1;
        check_eq("t5_acc_dwait", bus.dwait[0], 1'b0);
        cycle();
        bus.dREN = '0; bus.dWEN = '0; bus.ramstate = FREE;
        cycle();

        // Asynchronous reset in the middle of a held grant.
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h800;
        cycle();
        bus.ramstate = BUSY; #1;
        check_eq("t6_pre_ren", bus.ramREN, 1'b1);
        #2;
        nRST = 1'b0; #1;
        check_eq("t6_rst_ren", bus.ramREN, 1'b0);
        check_eq("t6_rst_wen", bus.ramWEN, 1'b0);
        check_eq("t6_rst_iwait", bus.iwait, 2'b11);
        check_eq("t6_rst_dwait", bus.dwait, 2'b11);
        m_reset();
        @(negedge CLK);
        nRST = 1'b1;
        bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h900; bus.ramstate = FREE;
        cycle();
        bus.ramstate = ACCESS; #1;
        check_eq("t6_rr_addr", bus.ramaddr, 32'h900);
        cycle();
        clear_inputs();
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            drive_random();
            cycle();
        end
        clear_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port among the instruction and data caches of `CPUS` cores. It sits between the caches' `cache_control_if` request side and the RAM model. It arbitrates requests with data-before-instruction priority and round-robin across cores. A grant is held for multi-word cache bursts: fetch, writeback, and flush followed by the hit-count store. The block generates the per-cache `iwait`/`dwait` handshakes.

## Interface
- `CPUS`, 2: number of cores; requester count is 2*CPUS.
- `MAX_HOLD`, 8: maximum completed RAM accesses per grant before a forced release.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  CPUS  instruction read request, per core.
- `iaddr`  in  CPUS x 32  instruction address.
- `dREN`, `dWEN`  in  CPUS each  data read / write request.
- `daddr`, `dstore`  in  CPUS x 32  data address / write data.
- `iwait`, `dwait`  out  CPUS each  1 = access not complete this cycle.
- `iload`, `dload`  out  CPUS x 32  read data, a copy of `ramload` to every requester.
- `ramREN`, `ramWEN`  out  1 each  RAM strobes.
- `ramaddr`, `ramstore`  out  32 each  RAM address / write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
- Each core `c` has a data requester, `dreq[c] = dREN[c]|dWEN[c]`, and an instruction requester, `ireq[c] = iREN[c]`.
- Two states: `ARB` (no grant) and `HOLD` (grant registered as `gcpu` plus `gtype` = D/I).
- **ARB**:
  - If any `dreq` is pending, pick the first pending data requester scanning from `rr_ptr` upward, with wrap-around.
  - Otherwise pick the first pending `ireq` by the same scan.
  - Register the grant, go to `HOLD`, and clear the access counter `hold_cnt`.
  - With no request pending, stay in `ARB`.
- **HOLD**: the granted requester's signals drive the RAM combinationally.
  - Data write: `ramWEN = dWEN`, `ramaddr = daddr`, `ramstore = dstore`.
  - Data read: `ramREN = dREN & ~dWEN`. If `dREN` and `dWEN` are both high, the write wins.
  - Instruction: `ramREN = 1`, `ramaddr = iaddr`.
- Completion is a cycle in `HOLD` with `ramstate == ACCESS`:
  - the granted requester's wait goes 0 for that cycle;
  - `hold_cnt` increments, saturating at `MAX_HOLD`.
- `ERROR` is not a completion: wait stays 1 and the request is re-presented (retry). `BUSY` and `FREE` leave wait at 1.
- **Release**: HOLD → ARB on the clock edge after a cycle in which either:
  - the granted requester's request is deasserted; or
  - a completion occurs with `hold_cnt == MAX_HOLD-1`.
- On release, `rr_ptr <= (gcpu+1) mod CPUS`.
- Release on deasserted request takes effect in the same cycle: RAM strobes are 0 once the request is low.
- A requester that drops and reasserts its request must re-arbitrate.
- Every non-granted requester sees wait = 1 continuously.

## Timing
- A fresh grant costs one arbitration cycle. A request seen in `ARB` at cycle n drives RAM at cycle n+1, and the earliest completion is cycle n+1.
- A held grant adds no bubble between accesses: burst word 2 is issued in the cycle after word 1 completes.
- Waits are combinational from `ramstate` and the registered grant. There is no registered latency on the data path.
- Reset (asynchronous, any time including mid-burst):
  - state = `ARB`, `rr_ptr` = 0, `hold_cnt` = 0;
  - `ramREN` = `ramWEN` = 0, `ramaddr` = `ramstore` = 0;
  - all `iwait`/`dwait` = 1.
- Requests that arrive in the same cycle resolve in priority order: data over instruction, then core order from `rr_ptr`.
- A request arriving while another requester holds the grant is served only after release.

## Structure
- `cpu_types_pkg` holds `word_t` and `ramstate_t`, with encodings FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- The local enum `arb_state_t {ARB, HOLD}` lives in the module.
- One sub-module, `rr_picker`, parameterized by N:
  - inputs: request vector and start pointer;
  - outputs: one-hot grant and a valid bit;
  - purely combinational;
  - instantiated twice, once for data and once for instruction.

## Test plan
- **Single instruction fetch:** after reset, `iREN[0]=1`, `iaddr=0x40`, RAM returns ACCESS after 2 BUSY cycles → `ramREN=1`, `ramaddr=0x40` from cycle 1; `iwait[0]=0` only in cycle 3; `iload[0]=ramload`.
- **Data priority:** `iREN[0]` and `dREN[1]` asserted in the same cycle → data requester core 1 granted first; `iwait[0]` stays 1 until `dREN[1]` drops; `rr_ptr` becomes 0.
- **Burst hold:**
  - core 0 writes back `0x100`/`0x104` with `dWEN` held across both words, while `dREN[1]` is pending;
  - `ramaddr` sequence is `0x100`, `0x104` with no bubble;
  - core 1 is granted one cycle after `dWEN[0]` drops.
- **MAX_HOLD cap:** core 0 holds `dREN` for 10 accesses with `MAX_HOLD=8` and `dREN[1]` pending → forced release after the 8th completion; core 1 gets the next grant.
- **Write wins / ERROR:**
  - `dREN` and `dWEN` both high → `ramWEN=1`, `ramREN=0`;
  - `ramstate=ERROR` for 1 cycle then ACCESS → `dwait` stays 1 through the ERROR cycle and is 0 on the ACCESS cycle.
- **Reset mid-burst:** assert `nRST=0` while in `HOLD` → strobes go to 0 and all waits to 1 immediately; after release, arbitration restarts with `rr_ptr=0`.
